// File: rtl/sm4_round_sequencer.sv
// SM4 round sequencer: feeds a 4-word window and round key to a pipelined
// round-function stage for 32 rounds and returns the reverse-ordered block.
module sm4_round_sequencer #(
    parameter int WORD_WIDTH = 32,
    parameter int ROUNDS     = 32,
    parameter int RF_LATENCY = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*WORD_WIDTH-1:0]   in_data,
    input  logic                      in_dec,
    output logic [4:0]                rk_idx,
    input  logic [WORD_WIDTH-1:0]     rk,
    output logic [WORD_WIDTH-1:0]     rf_rk,
    output logic [WORD_WIDTH-1:0]     rf_x0,
    output logic [WORD_WIDTH-1:0]     rf_x1,
    output logic [WORD_WIDTH-1:0]     rf_x2,
    output logic [WORD_WIDTH-1:0]     rf_x3,
    output logic                      rf_stall,
    input  logic [WORD_WIDTH-1:0]     rf_x4,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*WORD_WIDTH-1:0]   out_data,
    output logic                      busy
);

    localparam int W  = WORD_WIDTH;
    localparam int RW = $clog2(ROUNDS);
    localparam int PW = $clog2(RF_LATENCY + 1);

    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(RF_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_d;

    logic [W-1:0]  w0, w1, w2, w3;
    logic [RW-1:0] round;
    logic [PW-1:0] phase;
    logic          dec;
    logic          accept;
    logic          shift;
    logic          step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        shift   = 1'b0;
        step    = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid && !hold) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!hold) begin
                    if (phase == LAST_PHASE) begin
                        shift = 1'b1;
                        if (round == LAST_ROUND) begin
                            state_d = DONE;
                        end
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready && !hold) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Window slides by one word per round; the last round leaves round at
    // its final value so rk_idx does not move on the DONE transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w0    <= '0;
            w1    <= '0;
            w2    <= '0;
            w3    <= '0;
            round <= '0;
            phase <= '0;
            dec   <= 1'b0;
        end else if (accept) begin
            w0    <= in_data[4*W-1:3*W];
            w1    <= in_data[3*W-1:2*W];
            w2    <= in_data[2*W-1:W];
            w3    <= in_data[W-1:0];
            round <= '0;
            phase <= '0;
            dec   <= in_dec;
        end else if (shift) begin
            w0    <= w1;
            w1    <= w2;
            w2    <= w3;
            w3    <= rf_x4;
            phase <= '0;
            if (round != LAST_ROUND) begin
                round <= round + RW'(1);
            end
        end else if (step) begin
            phase <= phase + PW'(1);
        end
    end

    assign in_ready  = (state == IDLE) && !hold;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rf_stall  = hold;
    assign rf_rk     = rk;
    assign rf_x0     = w0;
    assign rf_x1     = w1;
    assign rf_x2     = w2;
    assign rf_x3     = w3;
    assign out_data  = {w3, w2, w1, w0};
    assign rk_idx    = dec ? 5'(LAST_ROUND - round) : 5'(round);

endmodule

// File: tb/tb_sm4_round_sequencer.sv
// Bench for sm4_round_sequencer: key schedule, round-function pipe model
// and a word-level SM4 reference drive randomized and standard blocks.
module tb_sm4_round_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         hold;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_dec;
    logic [4:0]   rk_idx;
    logic [31:0]  rk;
    logic [31:0]  rf_rk;
    logic [31:0]  rf_x0, rf_x1, rf_x2, rf_x3;
    logic         rf_stall;
    logic [31:0]  rf_x4;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    sm4_round_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dec    (in_dec),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .rf_rk     (rf_rk),
        .rf_x0     (rf_x0),
        .rf_x1     (rf_x1),
        .rf_x2     (rf_x2),
        .rf_x3     (rf_x3),
        .rf_stall  (rf_stall),
        .rf_x4     (rf_x4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] STD_PT  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] STD_CT  = 128'h681edf34d206965e86b3e94f536e4246;

    logic [31:0] rk_mem [32];
    logic [31:0] rf_pipe [4];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    int          mon_err = 0;
    int          rkq[$];

    assign rk    = rk_mem[rk_idx];
    assign rf_x4 = rf_pipe[3];

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    function automatic logic [31:0] t_enc(input logic [31:0] x);
        logic [31:0] b;
        b = tau(x);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    function automatic logic [31:0] t_key(input logic [31:0] x);
        logic [31:0] b;
        b = tau(x);
        return b ^ rol(b, 13) ^ rol(b, 23);
    endfunction

    task automatic key_expand(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] ck;
        k[0] = mk[127:96] ^ 32'ha3b1bac6;
        k[1] = mk[95:64]  ^ 32'h56aa3350;
        k[2] = mk[63:32]  ^ 32'h677d9197;
        k[3] = mk[31:0]   ^ 32'hb27022dc;
        for (int i = 0; i < 32; i++) begin
            ck = {8'((4 * i) * 7), 8'((4 * i + 1) * 7),
                  8'((4 * i + 2) * 7), 8'((4 * i + 3) * 7)};
            k[i + 4] = k[i] ^ t_key(k[i + 1] ^ k[i + 2] ^ k[i + 3] ^ ck);
            rk_mem[i] = k[i + 4];
        end
    endtask

    function automatic logic [127:0] sm4_ref(input logic [127:0] blk, input logic d);
        logic [31:0] x [36];
        x[0] = blk[127:96];
        x[1] = blk[95:64];
        x[2] = blk[63:32];
        x[3] = blk[31:0];
        for (int i = 0; i < 32; i++) begin
            x[i + 4] = x[i] ^ t_enc(x[i + 1] ^ x[i + 2] ^ x[i + 3] ^ rk_mem[d ? 31 - i : i]);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // Four-stage round-function pipe, frozen by rf_stall.
    always @(posedge clk) begin
        if (!rf_stall) begin
            rf_pipe[0] <= rf_x0 ^ t_enc(rf_x1 ^ rf_x2 ^ rf_x3 ^ rf_rk);
            rf_pipe[1] <= rf_pipe[0];
            rf_pipe[2] <= rf_pipe[1];
            rf_pipe[3] <= rf_pipe[2];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy && !out_valid && !hold) rkq.push_back(int'(rk_idx));
        if (in_valid && in_ready) n_acc <= n_acc + 1;
        if (rf_stall !== hold || rf_rk !== rk || (busy && in_ready))
            mon_err <= mon_err + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_block(
        input logic [127:0] blk, input logic d, input logic [127:0] want,
        input int lat, input int h1, input int n1, input int h2, input int n2,
        input int rst_at, input bit keep, input int bp, input string tag);
        int acc, off, k, errs, a0;
        logic [127:0] snap;
        in_valid = 1'b1;
        in_data  = blk;
        in_dec   = d;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_accept"}, 128'(in_ready), 128'(1));
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
        rkq.delete();
        off = cyc - acc;
        while (!out_valid && off < 400) begin
            hold = (off >= h1 && off < h1 + n1) || (off >= h2 && off < h2 + n2);
            if (rst_at > 0 && off == rst_at) begin
                hold = 1'b0;
                rst  = 1'b1;
                #1;
                check({tag, "_rst_busy"}, 128'(busy), 128'(0));
                @(posedge clk); #1;
                rst = 1'b0;
                #1;
                check({tag, "_rst_state"},
                      {out_data, 1'b0},
                      {128'(0), 1'b0});
                check({tag, "_rst_flags"},
                      128'({busy, out_valid, in_ready, rk_idx}),
                      128'({1'b0, 1'b0, 1'b1, 5'd0}));
                return;
            end
            @(posedge clk); #1;
            off = cyc - acc;
        end
        hold = 1'b0;
        check({tag, "_lat"}, 128'(off), 128'(lat));
        check({tag, "_data"}, out_data, want);
        check({tag, "_rk_len"}, 128'(rkq.size()), 128'(160));
        errs = 0;
        for (int i = 0; i < rkq.size() && i < 160; i++) begin
            if (rkq[i] != (d ? 31 - i / 5 : i / 5)) errs++;
        end
        check({tag, "_rk_seq"}, 128'(errs), 128'(0));
        if (bp > 0) begin
            snap = out_data;
            errs = 0;
            a0 = n_acc;
            in_valid = 1'b1;
            repeat (bp) begin
                @(posedge clk); #1;
                if (!out_valid || out_data !== snap || in_ready || !busy) errs++;
            end
            in_valid = keep;
            check({tag, "_bp_stable"}, 128'(errs), 128'(0));
            check({tag, "_bp_noacc"}, 128'(n_acc - a0), 128'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, 128'({busy, out_valid}), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] blk, ct;
        int a0;
        rst = 1'b1;
        hold = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_dec = 1'b0;
        out_ready = 1'b0;
        key_expand(STD_KEY);
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", 128'({busy, out_valid, in_ready, rk_idx}),
              128'({1'b0, 1'b0, 1'b1, 5'd0}));
        check("reset_data", out_data, 128'(0));
        check("reset_window", 128'({rf_x0, rf_x1, rf_x2, rf_x3}), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        hold = 1'b1;
        #1;
        check("idle_hold", 128'({in_ready, rf_stall}), 128'({1'b0, 1'b1}));
        hold = 1'b0;
        @(posedge clk); #1;

        run_block(STD_PT, 1'b0, STD_CT, 161, -1, 0, -1, 0, 0, 1'b0, 0, "std_enc");
        run_block(STD_CT, 1'b1, STD_PT, 161, -1, 0, -1, 0, 0, 1'b0, 10, "std_dec");
        blk = {$urandom, $urandom, $urandom, $urandom};
        run_block(blk, 1'b0, sm4_ref(blk, 1'b0), 161, -1, 0, -1, 0, 0, 1'b0, 0, "second");
        run_block(STD_PT, 1'b0, STD_CT, 165, 28, 3, 163, 1, 0, 1'b0, 0, "hold");
        run_block(STD_PT, 1'b0, STD_CT, 161, -1, 0, -1, 0, 88, 1'b0, 0, "rst_mid");
        run_block(STD_PT, 1'b0, STD_CT, 161, -1, 0, -1, 0, 0, 1'b0, 0, "post_rst");

        a0 = n_acc;
        for (int i = 0; i < 3; i++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            run_block(blk, 1'(i & 1), sm4_ref(blk, 1'(i & 1)), 161,
                      -1, 0, -1, 0, 0, 1'b1, 0, "cont");
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("cont_accepts", 128'(n_acc - a0), 128'(3));

        key_expand({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 2; i++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            ct = sm4_ref(blk, 1'b0);
            run_block(blk, 1'b0, ct, 161, -1, 0, -1, 0, 0, 1'b0, 0, "rnd_enc");
            run_block(ct, 1'b1, blk, 161, -1, 0, -1, 0, 0, 1'b0, 0, "rnd_dec");
        end

        check("monitor", 128'(mon_err), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
